alsu_pipe: RTL and testbench
============================

// Module: alsu_pipe
// PURPOSE
//  Parametrised, handshaked successor to the 6-bit ALSU. Width is generic, multiply is iterative
//  (shift-add FSM), and ops are accepted/produced via valid/ready. Sits between operand sequencer
//  and result bus; leds/err flag illegal ops for board debug.
// PARAMETERS
//  WIDTH           6      operand/result width (>=2)
//  INPUT_PRIORITY  "A"    "A"|"B": operand chosen when both bypass or both red_op set
//  FULL_ADDER      "ON"   "ON": add uses cin; "OFF": cin ignored
//  LED_W           16     width of leds vector
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  in_valid   in   1        request valid
//  in_ready   out  1        block accepts request this cycle
//  a, b       in   WIDTH    signed operands
//  cin, serial_in, direction, red_op_a, red_op_b, bypass_a, bypass_b  in 1  control bits
//  opcode     in   3        0 OR,1 XOR,2 ADD,3 MUL,4 SHIFT,5 ROTATE,6/7 illegal
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer takes result
//  out        out  WIDTH    signed result
//  err        out  1        result belongs to an invalid request
//  leds       out  LED_W    error indicator
// BEHAVIOUR
//  - Reset: out=0, out_valid=0, err=0, leds=0, last=0, state=IDLE; in_ready=0 during rst.
//  - All request fields captured on accept (in_valid&&in_ready); no input use after accept.
//  - Invalid = opcode in {6,7}, or (red_op_a|red_op_b) with opcode not in {0,1}.
//  - FSM IDLE/MUL/HOLD. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  - IDLE, accept non-MUL (or any invalid/bypass): result in out next edge, out_valid=1 (latency 1).
//  - IDLE, accept valid MUL without bypass: go MUL, WIDTH cycles shift-add; then out_valid=1,
//    latency WIDTH+1 from accept. out = low WIDTH bits of a*b (two's complement).
//  - out_valid && !out_ready: out/err held stable, state HOLD; leave on out_ready.
//  - out_valid drops after out_ready unless a new result lands same edge (back-to-back at 1/clk).
//  - Priority: invalid -> out=0, err=1; else bypass (both set -> INPUT_PRIORITY); else opcode.
//  - OR/XOR: red_op selects |x or ^x zero-extended; both -> INPUT_PRIORITY; neither -> bitwise.
//  - ADD: a+b+cin, wraps mod 2^WIDTH.
//  - SHIFT/ROTATE operate on 'last' (last delivered non-error result), not operands:
//    direction=1 left {last[W-2:0],serial_in | last[W-1]}, 0 right.
//  - 'last' updates on every valid non-error result; error results leave it unchanged.
//  - leds: on error result leds<=~leds; on valid non-error result leds<=0.
//  - rst mid-MUL or mid-HOLD aborts; partial product discarded, no result emitted.
// CONFIGURATION
//  ALSU_SAT_EN defined: ADD saturates to [-2^(W-1), 2^(W-1)-1] on signed overflow.
//  ALSU_SAT_EN undefined: ADD wraps; no saturation logic synthesised.
// STRUCTURE
//  Package alsu_pkg: opcode enum (OP_OR..OP_ROT), fsm state enum, is_invalid() function.
//  Sub-module alsu_seq_mult: start/done shift-add multiplier, WIDTH param, WIDTH-cycle busy.
// TESTING (WIDTH=6, defaults)
//  1 OR a=6'h15 b=6'h0A -> out=6'h1F, err=0, out_valid 1 cycle after accept.
//  2 MUL a=-3 b=5 -> out=-15 (6'h31), out_valid exactly 7 cycles after accept; in_ready=0 between.
//  3 ADD a=20 b=15 cin=1 -> out=-28 (6'h24); with ALSU_SAT_EN out=31 (6'h1F).
//  4 opcode=6 twice then OR -> err=1 leds=FFFF, err=1 leds=0000, err=0 leds=0000, out=0 on errs.
//  5 out_ready=0 for 3 cycles after result -> out/out_valid stable, in_ready=0; resumes on release.
//  6 rst asserted cycle 3 of MUL -> out_valid=0, out=0 immediately; next OR completes normally.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared types for the handshaked ALSU: opcode and FSM encodings plus the
// request-legality rule used by the datapath.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR    = 3'd0,
    OP_XOR   = 3'd1,
    OP_ADD   = 3'd2,
    OP_MUL   = 3'd3,
    OP_SHIFT = 3'd4,
    OP_ROT   = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Reduction selects are only meaningful for the bitwise ops.
  function automatic logic is_invalid(input logic [2:0] op, input logic red_a,
                                      input logic red_b);
    return (op > 3'd5) || ((red_a || red_b) && (op != 3'd0) && (op != 3'd1));
  endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Iterative shift-add multiplier: loads on start, busy for WIDTH cycles, and
// presents the final partial sum combinationally while done is high.
module alsu_seq_mult #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  // Low WIDTH bits of an unsigned shift-add equal the two's-complement product bits.
  assign product = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done    = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Handshaked, width-generic ALSU with iterative multiply and error LEDs.
// Define ALSU_SAT_EN to make ADD saturate on signed overflow instead of wrapping.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 6,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    cin,
  input  logic                    serial_in,
  input  logic                    direction,
  input  logic                    red_op_a,
  input  logic                    red_op_b,
  input  logic                    bypass_a,
  input  logic                    bypass_b,
  input  logic [2:0]              opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out,
  output logic                    err,
  output logic [LED_W-1:0]        leds
);
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  state_e                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_out, r_last, w_res, w_ld_res;
  logic [WIDTH-1:0]        w_prod, w_red_x;
  logic [LED_W-1:0]        r_leds;
  logic                    r_vld, r_err, w_err, w_mul, w_sel_a;
  logic                    w_accept, w_start, w_mdone, w_load, w_ld_err;

  function automatic logic signed [WIDTH-1:0] add_op(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y,
                                                     input logic c);
`ifdef ALSU_SAT_EN
    localparam logic signed [WIDTH+1:0] SAT_MAX = (WIDTH+2)'(2**(WIDTH-1) - 1);
    localparam logic signed [WIDTH+1:0] SAT_MIN = ~SAT_MAX;
    logic signed [WIDTH+1:0] s;
    s = (WIDTH+2)'(x) + (WIDTH+2)'(y) + $signed({{(WIDTH+1){1'b0}}, c});
    if (s > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (s < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return s[WIDTH-1:0];
`else
    return x + y + WIDTH'(c);
`endif
  endfunction

  // Request decode: legality first, then bypass, then the opcode itself.
  always_comb begin
    w_err   = is_invalid(opcode, red_op_a, red_op_b);
    w_mul   = 1'b0;
    w_res   = '0;
    w_sel_a = red_op_a && (!red_op_b || PRIO_A);
    w_red_x = w_sel_a ? a : b;
    if (w_err) begin
      w_res = '0;
    end else if (bypass_a || bypass_b) begin
      w_res = (bypass_a && (!bypass_b || PRIO_A)) ? a : b;
    end else begin
      case (opcode)
        OP_OR:    w_res = (red_op_a || red_op_b) ? WIDTH'(|w_red_x) : (a | b);
        OP_XOR:   w_res = (red_op_a || red_op_b) ? WIDTH'(^w_red_x) : (a ^ b);
        OP_ADD:   w_res = add_op(a, b, USE_CIN & cin);
        OP_MUL:   w_mul = 1'b1;
        OP_SHIFT: w_res = direction ? {r_last[WIDTH-2:0], serial_in}
                                    : {serial_in, r_last[WIDTH-1:1]};
        OP_ROT:   w_res = direction ? {r_last[WIDTH-2:0], r_last[WIDTH-1]}
                                    : {r_last[0], r_last[WIDTH-1:1]};
        default:  w_res = '0;
      endcase
    end
  end

  assign in_ready = !rst && (r_state == ST_IDLE) && (!r_vld || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && w_mul;
  assign w_load   = (w_accept && !w_mul) || ((r_state == ST_MUL) && w_mdone);
  assign w_ld_res = (r_state == ST_MUL) ? w_prod : w_res;
  assign w_ld_err = (r_state != ST_MUL) && w_err;

  alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .a       (a),
    .b       (b),
    .done    (w_mdone),
    .product (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start)                w_state_nxt = ST_MUL;
        else if (r_vld && !out_ready) w_state_nxt = ST_HOLD;
      end
      ST_MUL:  if (w_mdone)   w_state_nxt = ST_IDLE;
      ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result stage: a new result may replace the consumed one on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= '0;
      r_last  <= '0;
      r_leds  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_vld <= 1'b1;
        r_err <= w_ld_err;
        r_out <= w_ld_res;
        if (w_ld_err) begin
          r_leds <= ~r_leds;
        end else begin
          r_leds <= '0;
          r_last <= w_ld_res;
        end
      end else if (out_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld;
  assign out       = r_out;
  assign err       = r_err;
  assign leds      = r_leds;

endmodule

// File: tb/tb_alsu_pipe.sv
// Bench for alsu_pipe (WIDTH=6, defaults): directed table, backpressure and
// reset-abort sequences, then randomized requests against an arithmetic model.
module tb_alsu_pipe;
  localparam int W    = 6;
  localparam int LW   = 16;
  localparam int MASK = (1 << W) - 1;
`ifdef ALSU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk, rst, in_valid, in_ready, cin, serial_in, direction;
  logic          red_op_a, red_op_b, bypass_a, bypass_b, out_valid, out_ready, err;
  logic [W-1:0]  a, b, out;
  logic [2:0]    opcode;
  logic [LW-1:0] leds;

  alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .serial_in(serial_in), .direction(direction), .red_op_a(red_op_a),
    .red_op_b(red_op_b), .bypass_a(bypass_a), .bypass_b(bypass_b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin, si, dir, ra, rb, ba, bb;
  } req_t;

  typedef struct {
    req_t r;
    int   eo;
    bit   ee;
    int   el;
    int   lat;
  } vec_t;

  int n_vec  = 0;
  int n_bad  = 0;
  int m_last = 0;
  int m_leds = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input int op, input int av, input int bv, input bit c,
                              input bit si, input bit dir, input bit ra, input bit rb,
                              input bit ba, input bit bb);
    req_t r;
    r.op = 3'(op); r.a = W'(av); r.b = W'(bv); r.cin = c; r.si = si; r.dir = dir;
    r.ra = ra; r.rb = rb; r.ba = ba; r.bb = bb;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.op  = 3'($urandom_range(0, 7));
    r.a   = W'($urandom);
    r.b   = W'($urandom);
    r.cin = 1'($urandom);
    r.si  = 1'($urandom);
    r.dir = 1'($urandom);
    r.ra  = ($urandom_range(0, 5) == 0);
    r.rb  = ($urandom_range(0, 5) == 0);
    r.ba  = ($urandom_range(0, 7) == 0);
    r.bb  = ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  task automatic drive(input req_t r);
    opcode = r.op; a = r.a; b = r.b; cin = r.cin; serial_in = r.si; direction = r.dir;
    red_op_a = r.ra; red_op_b = r.rb; bypass_a = r.ba; bypass_b = r.bb;
  endtask

  // Reference: operands as signed integers, results reduced mod 2^W.
  function automatic void model(input req_t r, output int eo, output bit ee,
                                output int el, output int elat);
    logic signed [W-1:0] ta, tb;
    int sa, sb, s, x;
    ta = r.a; tb = r.b; sa = ta; sb = tb;
    ee = (r.op >= 6) || ((r.ra || r.rb) && r.op >= 2);
    elat = 1;
    eo = 0;
    if (!ee) begin
      if (r.ba) eo = int'(r.a);
      else if (r.bb) eo = int'(r.b);
      else begin
        case (r.op)
          0, 1: begin
            if (r.ra || r.rb) begin
              x  = r.ra ? int'(r.a) : int'(r.b);
              eo = (r.op == 0) ? int'(x != 0) : ($countones(x) % 2);
            end else begin
              eo = (r.op == 0) ? int'(r.a | r.b) : int'(r.a ^ r.b);
            end
          end
          2: begin
            s = sa + sb + int'(r.cin);
            if (SAT && s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
            if (SAT && s < -(1 << (W-1))) s = -(1 << (W-1));
            eo = s & MASK;
          end
          3: begin
            eo   = (sa * sb) & MASK;
            elat = W + 1;
          end
          4: eo = r.dir ? (((m_last << 1) | int'(r.si)) & MASK)
                        : ((m_last >> 1) | (int'(r.si) << (W-1)));
          5: eo = r.dir ? (((m_last << 1) | (m_last >> (W-1))) & MASK)
                        : ((m_last >> 1) | ((m_last & 1) << (W-1)));
          default: eo = 0;
        endcase
      end
    end
    el = ee ? (~m_leds & ((1 << LW) - 1)) : 0;
  endfunction

  task automatic run(input req_t r, input string name, input int eo, input bit ee,
                     input int el, input int elat);
    int cyc;
    bit rdy_seen;
    @(negedge clk);
    drive(r);
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      check({name, " in_ready"}, int'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive(rand_req());
    cyc = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " latency"}, cyc, elat);
    check({name, " out"}, int'(out), eo);
    check({name, " err"}, int'(err), int'(ee));
    check({name, " leds"}, int'(leds), el);
    if (elat > 1) check({name, " in_ready busy"}, int'(rdy_seen), 0);
    m_leds = el;
    if (!ee) m_last = eo;
  endtask

  task automatic run_model(input req_t r, input string name);
    int eo, el, elat;
    bit ee;
    model(r, eo, ee, el, elat);
    run(r, name, eo, ee, el, elat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    int   seen;
    tbl[0]  = '{mk(0, 'h15, 'h0A, 0, 0, 0, 0, 0, 0, 0), 'h1F, 1'b0, 0, 1};
    tbl[1]  = '{mk(3, 'h3D, 'h05, 0, 0, 0, 0, 0, 0, 0), 'h31, 1'b0, 0, 7};
    tbl[2]  = '{mk(2, 'h14, 'h0F, 1, 0, 0, 0, 0, 0, 0), SAT ? 'h1F : 'h24, 1'b0, 0, 1};
    tbl[3]  = '{mk(6, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1, 'hFFFF, 1};
    tbl[4]  = '{mk(6, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1, 0, 1};
    tbl[5]  = '{mk(0, 'h01, 'h02, 0, 0, 0, 0, 0, 0, 0), 'h03, 1'b0, 0, 1};
    tbl[6]  = '{mk(4, 'h00, 'h00, 0, 1, 1, 0, 0, 0, 0), 'h07, 1'b0, 0, 1};
    tbl[7]  = '{mk(5, 'h00, 'h00, 0, 0, 0, 0, 0, 0, 0), 'h23, 1'b0, 0, 1};
    tbl[8]  = '{mk(1, 'h07, 'h00, 0, 0, 0, 1, 0, 0, 0), 'h01, 1'b0, 0, 1};
    tbl[9]  = '{mk(2, 'h01, 'h02, 0, 0, 0, 0, 1, 0, 0), 0, 1'b1, 'hFFFF, 1};
    tbl[10] = '{mk(3, 'h2A, 'h11, 0, 0, 0, 0, 0, 1, 1), 'h2A, 1'b0, 0, 1};
    tbl[11] = '{mk(0, 'h00, 'h3F, 0, 0, 0, 1, 1, 0, 0), 'h00, 1'b0, 0, 1};
    tbl[12] = '{mk(4, 'h00, 'h00, 0, 1, 0, 0, 0, 0, 0), 'h20, 1'b0, 0, 1};
    tbl[13] = '{mk(2, 'h20, 'h3F, 0, 0, 0, 0, 0, 0, 0), SAT ? 'h20 : 'h1F, 1'b0, 0, 1};
    tbl[14] = '{mk(3, 'h3F, 'h3F, 0, 0, 0, 0, 0, 0, 0), 'h01, 1'b0, 0, 7};
    tbl[15] = '{mk(7, 'h05, 'h05, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1, 'hFFFF, 1};
    tbl[16] = '{mk(5, 'h00, 'h00, 0, 0, 1, 0, 0, 0, 0), 'h02, 1'b0, 0, 1};
    tbl[17] = '{mk(1, 'h2C, 'h1B, 0, 0, 0, 0, 0, 0, 0), 'h37, 1'b0, 0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out", int'(out), 0);
    check("reset err", int'(err), 0);
    check("reset leds", int'(leds), 0);
    check("reset in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", int'(in_ready), 1);

    for (int i = 0; i < 18; i++)
      run(tbl[i].r, $sformatf("vec%0d", i), tbl[i].eo, tbl[i].ee, tbl[i].el, tbl[i].lat);

    // Backpressure: result must sit still while the consumer stalls.
    @(negedge clk);
    drive(mk(0, 'h01, 'h04, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp first out_valid", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp stall%0d out", i), int'(out), 'h05);
      check($sformatf("bp stall%0d out_valid", i), int'(out_valid), 1);
      check($sformatf("bp stall%0d in_ready", i), int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", int'(out_valid), 0);
    m_last = 'h05;
    m_leds = 0;
    run_model(mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0), "bp resume shift");

    // Reset in the middle of a multiply discards it.
    run_model(mk(0, 'h3F, 'h00, 0, 0, 0, 0, 0, 0, 0), "pre-rst or");
    run_model(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0), "pre-rst err");
    @(negedge clk);
    drive(mk(3, 'h03, 'h03, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid-mul rst out_valid", int'(out_valid), 0);
    check("mid-mul rst out", int'(out), 0);
    check("mid-mul rst leds", int'(leds), 0);
    check("mid-mul rst in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("aborted mul no result", seen, 0);
    m_last = 0;
    m_leds = 0;
    run_model(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0), "post-rst shift");
    run_model(mk(0, 'h15, 'h0A, 0, 0, 0, 0, 0, 0, 0), "post-rst or");

    for (int i = 0; i < 150; i++) run_model(rand_req(), $sformatf("rand%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
